// File: rtl/sha512_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sha512_arb_pkg
//  Purpose  : Shared widths and FSM state encoding for the SHA-512 core
//             arbiter and its round-robin helper.
//  Revision : 1.0  initial release
// ============================================================================
package sha512_arb_pkg;

    localparam int BLOCK_W  = 1024;
    localparam int DIGEST_W = 512;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        GUARD = 3'd2,
        BUSY  = 3'd3,
        OWNED = 3'd4,
        RESP  = 3'd5
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick. Scans the request vector
//             starting at ptr_i (wrapping) and returns the first hit as a
//             one-hot grant plus its index.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    // ptr_i is always below N, so a single conditional subtract wraps it.
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) begin
            s = s - N;
        end
        return IW'(s);
    endfunction

    // First asserted request at or after the pointer wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid_o && req_i[wrap_idx(ptr_i, k)]) begin
                valid_o                     = 1'b1;
                idx_o                       = wrap_idx(ptr_i, k);
                grant_o[wrap_idx(ptr_i, k)] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sha512_core_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : sha512_core_arbiter
//  Purpose  : Shares one sha512_core between NUM_REQ requesters. A requester
//             that wins with a first block owns the core until its last
//             block's digest is handed back (or until an idle timeout).
//             All core sequencing (init/next pulses, ready tracking, block
//             hold) lives here. At integration the core is tied to
//             mode=2'b11 and reset_n=~rst.
//  Revision : 1.0  initial release
// ============================================================================
module sha512_core_arbiter
    import sha512_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ-1:0]         req_first_i,
    input  logic [NUM_REQ-1:0]         req_last_i,
    input  logic [NUM_REQ*BLOCK_W-1:0] req_block_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [NUM_REQ-1:0]         rsp_valid_o,
    input  logic [NUM_REQ-1:0]         rsp_ready_i,
    output logic [DIGEST_W-1:0]        rsp_digest_o,
    output logic [NUM_REQ-1:0]         rsp_abort_o,
    output logic                       sha_init_o,
    output logic                       sha_next_o,
    output logic [BLOCK_W-1:0]         sha_block_o,
    input  logic                       sha_ready_i,
    input  logic [DIGEST_W-1:0]        sha_digest_i,
    input  logic                       sha_digest_valid_i
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    arb_state_t          state_q,  state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       owner_q,  owner_d;
    logic                last_q,   last_d;
    logic                init_q,   init_d;
    logic                next_q,   next_d;
    logic [BLOCK_W-1:0]  block_q,  block_d;
    logic [DIGEST_W-1:0] digest_q, digest_d;
    logic [TW-1:0]       timer_q,  timer_d;

    logic [NUM_REQ-1:0]  w_cand;
    logic [NUM_REQ-1:0]  w_grant;
    logic [NUM_REQ-1:0]  w_owner_oh;
    logic [IW-1:0]       w_win;
    logic                w_any;

    // Only message starts compete, and only while the core is idle.
    assign w_cand     = req_valid_i & req_first_i & {NUM_REQ{sha_ready_i}};
    assign w_owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req_i   (w_cand),
        .ptr_i   (rr_ptr_q),
        .grant_o (w_grant),
        .idx_o   (w_win),
        .valid_o (w_any)
    );

    assign sha_init_o   = init_q;
    assign sha_next_o   = next_q;
    assign sha_block_o  = block_q;
    assign rsp_digest_o = digest_q;

    // Next-state and handshake outputs. init/next are computed on the
    // transition into ISSUE so their registered copies are high exactly there.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        last_d      = last_q;
        init_d      = 1'b0;
        next_d      = 1'b0;
        block_d     = block_q;
        digest_d    = digest_q;
        timer_d     = timer_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_abort_o = '0;
        case (state_q)
            IDLE: begin
                if (w_any) begin
                    req_ready_o = w_grant;
                    block_d     = req_block_i[w_win*BLOCK_W +: BLOCK_W];
                    last_d      = req_last_i[w_win];
                    owner_d     = w_win;
                    rr_ptr_d    = (w_win == IW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
                    init_d      = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: state_d = GUARD;
            // The core lowers ready one cycle after the pulse; skip that cycle.
            GUARD: state_d = BUSY;
            BUSY: begin
                if (sha_ready_i) begin
                    if (!last_q) begin
                        timer_d = '0;
                        state_d = OWNED;
                    end else if (sha_digest_valid_i) begin
                        digest_d = sha_digest_i;
                        state_d  = RESP;
                    end
                end
            end
            OWNED: begin
                if (req_valid_i[owner_q]) begin
                    // A first block here restarts the owner's message.
                    req_ready_o = w_owner_oh;
                    block_d     = req_block_i[owner_q*BLOCK_W +: BLOCK_W];
                    last_d      = req_last_i[owner_q];
                    init_d      = req_first_i[owner_q];
                    next_d      = ~req_first_i[owner_q];
                    state_d     = ISSUE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    rsp_abort_o = w_owner_oh;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                rsp_valid_o = w_owner_oh;
                if (rsp_ready_i[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any message in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            last_q   <= 1'b0;
            init_q   <= 1'b0;
            next_q   <= 1'b0;
            block_q  <= '0;
            digest_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            init_q   <= init_d;
            next_q   <= next_d;
            block_q  <= block_d;
            digest_q <= digest_d;
            timer_q  <= timer_d;
        end
    end

endmodule
`default_nettype wire
